// File: rtl/teng_pkg.sv
// ---------------------------------------------------------------------------
// teng_pkg
// Shared definitions for the TENG stimulus path: the motion sequencer
// state type, the phase codes reported to the mixed-signal bench, and the
// default code width used by the TENG model and downstream sense blocks.
// ---------------------------------------------------------------------------
package teng_pkg;

  // Default gap/charge code width expected by the TENG behavioural model
  localparam int W_DEF = 4;

  // Contact-separation cycle: close, hold closed, open, hold open
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLOSE  = 3'd1,
    S_HOLD_C = 3'd2,
    S_OPEN   = 3'd3,
    S_HOLD_O = 3'd4
  } state_t;

  // Phase codes; IDLE and HOLD_O share code 0 (plates fully separated)
  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_CLOSE  = 2'd1;
  localparam logic [1:0] PH_HOLD_C = 2'd2;
  localparam logic [1:0] PH_OPEN   = 2'd3;

  // Map a sequencer state onto its reported phase code
  function automatic logic [1:0] phase_of(input state_t s);
    logic [1:0] ph;
    ph = PH_IDLE;
    case (s)
      S_CLOSE:  ph = PH_CLOSE;
      S_HOLD_C: ph = PH_HOLD_C;
      S_OPEN:   ph = PH_OPEN;
      default:  ph = PH_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/teng_step_timer.sv
// ---------------------------------------------------------------------------
// teng_step_timer
// Reloadable down-counter shared by the sequencer for both the gap-step
// divider and the hold-phase timer.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset (count cleared)
//   load     - reload the count with load_val (wins over en)
//   load_val - reload value; the timer expires load_val+1 clocks after load
//   en       - count down by one while non-zero
//   tc       - terminal count, high while the count is zero
// ---------------------------------------------------------------------------
module teng_step_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          tc
);

  logic [CW-1:0] cnt;

  // Count register: reload has priority, counting stops at zero so tc
  // stays asserted until the owner reloads the timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/teng_motion_seq.sv
// ---------------------------------------------------------------------------
// teng_motion_seq
// Stimulus sequencer feeding the TENG behavioural model. Repeats a
// close / hold / open / hold cycle on the gap code and tracks the
// transferred-charge code alongside it.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset, aborts any cycle
//   start      - level request to begin cycling (ignored while busy)
//   stop       - finish the current cycle, then return to idle
//   q_clr      - synchronous clear of q_out, beats any step update
//   x_out      - gap code to the model X input (X_MAX = fully separated)
//   q_out      - charge code to the model Q input
//   phase      - 0 idle/hold-open, 1 close, 2 hold-closed, 3 open
//   busy       - high in every state except idle
//   cycle_done - one-clock pulse when a full cycle completes
//   cycle_cnt  - completed cycles, wraps 255 -> 0
// ---------------------------------------------------------------------------
module teng_motion_seq
  import teng_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int X_MAX    = 12,
  parameter int STEP_DIV = 2,
  parameter int HOLD_CYC = 4,
  parameter int Q_STEP   = 1,
  parameter int Q_MAX    = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         q_clr,
  output logic [W-1:0] x_out,
  output logic [W-1:0] q_out,
  output logic [1:0]   phase,
  output logic         busy,
  output logic         cycle_done,
  output logic [7:0]   cycle_cnt
);

  localparam int TW = 16;

  // Reject parameter sets the model or the timer cannot represent
  if (W != W_DEF) begin : g_bad_w
    $error("teng_motion_seq: W must equal W_DEF");
  end
  if ((X_MAX < 1) || (X_MAX > (1 << W) - 1)) begin : g_bad_xmax
    $error("teng_motion_seq: X_MAX out of range");
  end
  if ((STEP_DIV < 1) || (STEP_DIV > (1 << TW))) begin : g_bad_div
    $error("teng_motion_seq: STEP_DIV out of range");
  end
  if ((HOLD_CYC < 1) || (HOLD_CYC > (1 << TW))) begin : g_bad_hold
    $error("teng_motion_seq: HOLD_CYC out of range");
  end
  if ((Q_STEP < 0) || (Q_STEP > (1 << W) - 1)) begin : g_bad_qstep
    $error("teng_motion_seq: Q_STEP out of range");
  end
  if ((Q_MAX < 0) || (Q_MAX > (1 << W) - 1)) begin : g_bad_qmax
    $error("teng_motion_seq: Q_MAX out of range");
  end

  localparam logic [W-1:0]  XM      = W'(X_MAX);
  localparam logic [W-1:0]  QM      = W'(Q_MAX);
  localparam logic [W-1:0]  QS      = W'(Q_STEP);
  // Timer expires load value + 1 clocks after the load edge
  localparam logic [TW-1:0] STEP_LD = TW'(STEP_DIV - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);

  state_t         state, state_nxt;
  logic [W-1:0]   x_nxt, q_nxt, q_up, q_dn;
  logic [W:0]     q_sum;
  logic           busy_nxt, done_nxt, stop_pend, stop_pend_nxt;
  logic [7:0]     cnt_nxt;
  logic           tmr_load, tmr_en, tmr_tc;
  logic [TW-1:0]  tmr_val;

  teng_step_timer #(.CW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  // Saturating charge arithmetic; one extra bit catches the upward carry
  always_comb begin
    q_sum = {1'b0, q_out} + {1'b0, QS};
    q_up  = (q_sum > {1'b0, QM}) ? QM : q_sum[W-1:0];
    q_dn  = (q_out > QS) ? (q_out - QS) : '0;
  end

  // Next-state and registered-output logic. The timer is reloaded on every
  // phase entry and after every gap step, so each step lands exactly
  // STEP_DIV clocks after the previous one.
  always_comb begin
    state_nxt     = state;
    x_nxt         = x_out;
    q_nxt         = q_out;
    done_nxt      = 1'b0;
    cnt_nxt       = cycle_cnt;
    stop_pend_nxt = stop_pend;
    tmr_load      = 1'b0;
    tmr_val       = STEP_LD;
    tmr_en        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_nxt = S_CLOSE;
          tmr_load  = 1'b1;
        end
      end
      S_CLOSE: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          q_nxt    = q_up;
          tmr_load = 1'b1;
          if (x_out <= W'(1)) begin
            x_nxt     = '0;
            state_nxt = S_HOLD_C;
            tmr_val   = HOLD_LD;
          end else begin
            x_nxt = x_out - 1'b1;
          end
        end
      end
      S_HOLD_C: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          state_nxt = S_OPEN;
          tmr_load  = 1'b1;
        end
      end
      S_OPEN: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          q_nxt    = q_dn;
          tmr_load = 1'b1;
          if (x_out >= XM - 1'b1) begin
            x_nxt     = XM;
            state_nxt = S_HOLD_O;
            tmr_val   = HOLD_LD;
          end else begin
            x_nxt = x_out + 1'b1;
          end
        end
      end
      S_HOLD_O: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          done_nxt = 1'b1;
          cnt_nxt  = cycle_cnt + 8'd1;
          if (stop_pend) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_CLOSE;
            tmr_load  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // A stop while cycling is remembered until the cycle ends in idle
    if ((state != S_IDLE) && stop) begin
      stop_pend_nxt = 1'b1;
    end
    if (state_nxt == S_IDLE) begin
      stop_pend_nxt = 1'b0;
    end

    if (q_clr) begin
      q_nxt = '0;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and output registers; reset aborts any cycle immediately
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      x_out      <= XM;
      q_out      <= '0;
      busy       <= 1'b0;
      cycle_done <= 1'b0;
      cycle_cnt  <= '0;
      stop_pend  <= 1'b0;
    end else begin
      state      <= state_nxt;
      x_out      <= x_nxt;
      q_out      <= q_nxt;
      busy       <= busy_nxt;
      cycle_done <= done_nxt;
      cycle_cnt  <= cnt_nxt;
      stop_pend  <= stop_pend_nxt;
    end
  end

  assign phase = phase_of(state);

endmodule

// File: tb/tb_teng_motion_seq.sv
// ---------------------------------------------------------------------------
// tb_teng_motion_seq
// Directed bench for teng_motion_seq. A default instance is exercised
// through all scenarios; a second instance with Q_MAX=8 shares the inputs
// to show charge saturation. Inputs change and outputs are sampled on the
// falling clock edge. Times are counted in rising edges k since the edge
// that entered CLOSE (one cycle = 56 edges with defaults).
// ---------------------------------------------------------------------------
module tb_teng_motion_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       q_clr = 1'b0;

  logic [3:0] x_out, q_out;
  logic [1:0] phase;
  logic       busy, cycle_done;
  logic [7:0] cycle_cnt;

  logic [3:0] x8, q8;
  logic [1:0] phase8;
  logic       busy8, done8;
  logic [7:0] cnt8;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  teng_motion_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .q_clr      (q_clr),
    .x_out      (x_out),
    .q_out      (q_out),
    .phase      (phase),
    .busy       (busy),
    .cycle_done (cycle_done),
    .cycle_cnt  (cycle_cnt)
  );

  teng_motion_seq #(.Q_MAX(8)) dut_q8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .q_clr      (q_clr),
    .x_out      (x8),
    .q_out      (q8),
    .phase      (phase8),
    .busy       (busy8),
    .cycle_done (done8),
    .cycle_cnt  (cnt8)
  );

  always #5 clk = ~clk;

  // Expected gap code k edges into a default cycle
  function automatic int exp_x(input int k);
    if (k <= 24) return 12 - k / 2;
    if (k < 28)  return 0;
    if (k <= 52) return (k - 28) / 2;
    return 12;
  endfunction

  // Expected charge code k edges into a cycle starting from q=0
  function automatic int exp_q(input int k, input int qmax);
    int top;
    int v;
    top = (12 < qmax) ? 12 : qmax;
    if (k <= 24) begin
      v = k / 2;
      return (v < qmax) ? v : qmax;
    end
    if (k < 28) return top;
    if (k <= 52) begin
      v = top - (k - 28) / 2;
      return (v > 0) ? v : 0;
    end
    return 0;
  endfunction

  // Expected phase code k edges into a cycle
  function automatic int exp_phase(input int k);
    if (k < 24) return 1;
    if (k < 28) return 2;
    if (k < 52) return 3;
    return 0;
  endfunction

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input int observed, input int expected);
    assert_cnt++;
    if (observed != expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive the control inputs, then let n rising edges pass
  task automatic applyStimulus(input logic s, input logic p, input logic c, input int n);
    start = s;
    stop  = p;
    q_clr = c;
    repeat (n) @(negedge clk);
  endtask

  // Abort the run if the sequence ever stalls
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got 0 expected 1");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);

    // Scenario 1: reset values, then one full default cycle edge by edge
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("rst_x", x_out, 12);
    checkOutput("rst_q", q_out, 0);
    checkOutput("rst_phase", phase, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", cycle_done, 0);
    checkOutput("rst_cnt", cycle_cnt, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("idle_busy", busy, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    for (int k = 0; k <= 56; k++) begin
      checkOutput("s1_x", x_out, exp_x(k % 56));
      checkOutput("s1_q", q_out, exp_q(k % 56, 15));
      checkOutput("s1_phase", phase, exp_phase(k % 56));
      checkOutput("s1_busy", busy, 1);
      checkOutput("s1_done", cycle_done, (k == 56) ? 1 : 0);
      checkOutput("s1_cnt", cycle_cnt, (k == 56) ? 1 : 0);
      checkOutput("s1_q8", q8, exp_q(k % 56, 8));
      if (k < 56) applyStimulus(1'b0, 1'b0, 1'b0, 1);
    end

    // Scenario 3: stop in the OPEN phase of cycle 3 lets it finish
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("s3_done_pulse", cycle_done, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 55);
    checkOutput("s3_cnt2", cycle_cnt, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 40);
    checkOutput("s3_phase_open", phase, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("s3_no_trunc_phase", phase, 3);
    checkOutput("s3_no_trunc_x", x_out, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 15);
    checkOutput("s3_done", cycle_done, 1);
    checkOutput("s3_cnt3", cycle_cnt, 3);
    checkOutput("s3_busy", busy, 0);
    checkOutput("s3_phase_idle", phase, 0);
    checkOutput("s3_x", x_out, 12);
    checkOutput("s3_q", q_out, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    checkOutput("s3_still_x", x_out, 12);
    checkOutput("s3_still_busy", busy, 0);
    checkOutput("s3_still_cnt", cycle_cnt, 3);

    // Scenario 4: start with stop stays idle; start while busy is ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("s4_busy", busy, 0);
    checkOutput("s4_phase", phase, 0);
    checkOutput("s4_x", x_out, 12);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("s4_go_busy", busy, 1);
    checkOutput("s4_go_phase", phase, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    checkOutput("s4_x_k10", x_out, 7);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("s4_restart_phase", phase, 1);
      checkOutput("s4_restart_x", x_out, exp_x(11 + i));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 12);
    checkOutput("s4_hold_c_phase", phase, 2);
    checkOutput("s4_hold_c_x", x_out, 0);

    // Scenario 5: reset in HOLD_C, then a fresh start
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("s5_x", x_out, 12);
    checkOutput("s5_q", q_out, 0);
    checkOutput("s5_busy", busy, 0);
    checkOutput("s5_cnt", cycle_cnt, 0);
    checkOutput("s5_phase", phase, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("s5_idle_busy", busy, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("s5_go_busy", busy, 1);
    checkOutput("s5_go_x", x_out, 12);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("s5_x_k2", x_out, 11);
    checkOutput("s5_q_k2", q_out, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 54);
    checkOutput("s5_done", cycle_done, 1);
    checkOutput("s5_cnt", cycle_cnt, 1);
    checkOutput("s5_x_end", x_out, 12);

    // Scenario 6: q_clr beats a CLOSE step, then wrap the cycle counter
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("s6_qclr_q", q_out, 0);
    checkOutput("s6_qclr_x", x_out, 11);
    checkOutput("s6_qclr_q8", q8, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("s6_q_k4", q_out, 1);
    checkOutput("s6_x_k4", x_out, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 24);
    checkOutput("s6_q_k28", q_out, 11);
    checkOutput("s6_phase_k28", phase, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 28);
    checkOutput("s6_q_floor", q_out, 0);
    checkOutput("s6_cnt2", cycle_cnt, 2);
    repeat (253) applyStimulus(1'b0, 1'b0, 1'b0, 56);
    checkOutput("s6_cnt255", cycle_cnt, 255);
    applyStimulus(1'b0, 1'b0, 1'b0, 56);
    checkOutput("s6_wrap_cnt", cycle_cnt, 0);
    checkOutput("s6_wrap_done", cycle_done, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 55);
    checkOutput("s6_stop_busy", busy, 0);
    checkOutput("s6_stop_phase", phase, 0);
    checkOutput("s6_stop_cnt", cycle_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
